io_hub_stream: RTL and testbench

//  Parametrised successor of the IO hub: memory-mapped bridge between the CPU peripheral bus
//  (io_stb/io_we/io_addr/io_dat, ack handshake) and an external byte-serial link (UART core).
//  Has single-clock RX/TX FIFOs, byte or multi-byte word framing, sticky error flags and an

---
 rtl/io_hub_stream.sv | 228 ++++++++++++++++++++++
 tb/tb_io_hub_stream.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_hub_stream.sv
// Bus-mapped bridge between the CPU peripheral bus and a byte-serial UART core.
// Single-clock RX/TX FIFOs, byte or DW/8-byte word framing, sticky error flags and an interrupt.
module io_hub_stream #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          io_stb_i,
    input  logic          io_we_i,
    input  logic [AW-1:0] io_addr_i,
    input  logic [DW-1:0] io_dat_i,
    output logic          io_ack_o,
    output logic [DW-1:0] io_dat_o,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_valid_i,
    output logic [7:0]    tx_byte_o,
    output logic          tx_start_o,
    input  logic          tx_busy_i,
    output logic          irq_o
);
    localparam int NB  = DW / 8;
    localparam int BIW = $clog2(NB);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam logic [AW-1:0] A_STATUS = AW'(0);
    localparam logic [AW-1:0] A_CTRL   = AW'(2);
    localparam logic [AW-1:0] A_TXDATA = AW'(4);
    localparam logic [AW-1:0] A_RXDATA = AW'(6);
    localparam logic [AW-1:0] A_CLEAR  = AW'(8);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO} tx_state_e;

    tx_state_e       state_q, state_d;
    logic            ack_q, ack_d, irq_q, irq_d, ovr_q, ovr_d, ovf_q, ovf_d;
    logic [DW-1:0]   dat_q, dat_d, asm_q, asm_d, txw_q, txw_d;
    logic [4:0]      ctrl_q, ctrl_d;
    logic [BIW-1:0]  asm_idx_q, asm_idx_d, tx_idx_q, tx_idx_d;
    logic            tx_wm_q, tx_wm_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [DW-1:0]   rx_mem_q [RX_DEPTH];
    logic [DW-1:0]   rx_mem_d [RX_DEPTH];
    logic [DW-1:0]   tx_mem_q [TX_DEPTH];
    logic [DW-1:0]   tx_mem_d [TX_DEPTH];
    logic [RXA-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RXA:0]    rx_cnt_q, rx_cnt_d;
    logic [TXA-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TXA:0]    tx_cnt_q, tx_cnt_d;

    logic accept, is_wr, is_rd, flush, clr_asm;
    logic rx_empty, rx_full, tx_empty, tx_full, tx_active;
    logic rx_push, rx_pop, rx_wr, tx_wr, tx_pop;
    logic [DW-1:0] rx_wdata, rdata;

    always_comb begin
        accept    = io_stb_i && !ack_q;
        is_wr     = accept && io_we_i;
        is_rd     = accept && !io_we_i;
        rx_empty  = (rx_cnt_q == '0);
        rx_full   = (rx_cnt_q == (RXA+1)'(RX_DEPTH));
        tx_empty  = (tx_cnt_q == '0);
        tx_full   = (tx_cnt_q == (TXA+1)'(TX_DEPTH));
        tx_active = (state_q != S_IDLE);
        flush     = is_wr && (io_addr_i == A_CTRL) && io_dat_i[5];
        clr_asm   = flush || (is_wr && (io_addr_i == A_CTRL) && (io_dat_i[2] != ctrl_q[2]));
        rx_pop    = is_rd && (io_addr_i == A_RXDATA) && !rx_empty;

        rdata = '0;
        if (io_addr_i == A_STATUS)
            rdata[6:0] = {ovf_q, ovr_q, tx_active, tx_full, tx_empty, rx_full, rx_empty};
        else if (io_addr_i == A_CTRL)
            rdata[4:0] = ctrl_q;
        else if (io_addr_i == A_RXDATA && !rx_empty)
            rdata = rx_mem_q[rx_rp_q];
        ack_d = accept;
        dat_d = is_rd ? rdata : '0;
        ctrl_d = (is_wr && io_addr_i == A_CTRL) ? io_dat_i[4:0] : ctrl_q;

        // RX framing; a word-mode change or flush discards any partial word
        asm_d     = asm_q;
        asm_idx_d = asm_idx_q;
        rx_push   = 1'b0;
        rx_wdata  = '0;
        if (rx_valid_i && ctrl_q[0]) begin
            if (ctrl_q[2]) begin
                asm_d[8*int'(asm_idx_q) +: 8] = rx_byte_i;
                if (asm_idx_q == BIW'(NB-1)) begin
                    rx_push   = 1'b1;
                    rx_wdata  = asm_d;
                    asm_idx_d = '0;
                end else begin
                    asm_idx_d = asm_idx_q + 1'b1;
                end
            end else begin
                rx_push  = 1'b1;
                rx_wdata = DW'(rx_byte_i);
            end
        end
        if (clr_asm) begin
            asm_d     = '0;
            asm_idx_d = '0;
            if (ctrl_q[2]) rx_push = 1'b0;
        end

        ovr_d = ovr_q;
        ovf_d = ovf_q;
        if (is_wr && io_addr_i == A_CLEAR) begin
            if (io_dat_i[5]) ovr_d = 1'b0;
            if (io_dat_i[6]) ovf_d = 1'b0;
        end

        rx_wr = 1'b0;
        if (rx_push && !flush) begin
            if (rx_full && !rx_pop) ovr_d = 1'b1;
            else                    rx_wr = 1'b1;
        end
        rx_mem_d = rx_mem_q;
        if (rx_wr) rx_mem_d[rx_wp_q] = rx_wdata;
        rx_wp_d  = rx_wp_q + RXA'(rx_wr);
        rx_rp_d  = rx_rp_q + RXA'(rx_pop);
        rx_cnt_d = rx_cnt_q + (RXA+1)'(rx_wr) - (RXA+1)'(rx_pop);

        // TX engine: a word already popped is always sent to completion
        state_d   = state_q;
        tx_pop    = 1'b0;
        txw_d     = txw_q;
        tx_idx_d  = tx_idx_q;
        tx_wm_d   = tx_wm_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            S_IDLE: if (ctrl_q[1] && !tx_empty && !flush) begin
                tx_pop    = 1'b1;
                txw_d     = tx_mem_q[tx_rp_q];
                tx_idx_d  = '0;
                tx_wm_d   = ctrl_q[2];
                tx_byte_d = txw_d[7:0];
                state_d   = S_LOAD;
            end
            S_LOAD:    state_d = S_WAIT_HI;
            S_WAIT_HI: if (tx_busy_i) state_d = S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy_i) begin
                if (!tx_wm_q || tx_idx_q == BIW'(NB-1)) begin
                    state_d = S_IDLE;
                end else begin
                    tx_idx_d  = tx_idx_q + 1'b1;
                    tx_byte_d = txw_q[8*int'(tx_idx_d) +: 8];
                    state_d   = S_LOAD;
                end
            end
            default:   state_d = S_IDLE;
        endcase

        tx_wr = 1'b0;
        if (is_wr && io_addr_i == A_TXDATA) begin
            if (tx_full) ovf_d = 1'b1;
            else         tx_wr = 1'b1;
        end
        tx_mem_d = tx_mem_q;
        if (tx_wr) tx_mem_d[tx_wp_q] = io_dat_i;
        tx_wp_d  = tx_wp_q + TXA'(tx_wr);
        tx_rp_d  = tx_rp_q + TXA'(tx_pop);
        tx_cnt_d = tx_cnt_q + (TXA+1)'(tx_wr) - (TXA+1)'(tx_pop);

        if (flush) begin
            rx_wp_d = '0; rx_rp_d = '0; rx_cnt_d = '0;
            tx_wp_d = '0; tx_rp_d = '0; tx_cnt_d = '0;
        end

        irq_d = (ctrl_q[3] && !rx_empty) || (ctrl_q[4] && tx_empty && !tx_active) || ovr_q || ovf_q;
    end

    always_ff @(posedge clk_i) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
            ovr_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ctrl_q    <= '0;
            asm_q     <= '0;
            asm_idx_q <= '0;
            txw_q     <= '0;
            tx_idx_q  <= '0;
            tx_wm_q   <= 1'b0;
            tx_byte_q <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_cnt_q  <= '0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
            ovr_q     <= ovr_d;
            ovf_q     <= ovf_d;
            ctrl_q    <= ctrl_d;
            asm_q     <= asm_d;
            asm_idx_q <= asm_idx_d;
            txw_q     <= txw_d;
            tx_idx_q  <= tx_idx_d;
            tx_wm_q   <= tx_wm_d;
            tx_byte_q <= tx_byte_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end

    assign io_ack_o   = ack_q;
    assign io_dat_o   = dat_q;
    assign tx_byte_o  = tx_byte_q;
    assign tx_start_o = (state_q == S_LOAD);
    assign irq_o      = irq_q;
endmodule

// File: tb/tb_io_hub_stream.sv
// Bench for io_hub_stream: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized soak.
module tb_io_hub_stream;
    localparam int DW = 16, AW = 16, RXD = 16, TXD = 16, NB = DW / 8;

    logic          clk = 1'b0, rst, stb, we, ack, rxv, txs, busy, irq;
    logic [AW-1:0] addr;
    logic [DW-1:0] dati, dato;
    logic [7:0]    rxb, txb;

    io_hub_stream #(.DW(DW), .AW(AW), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk_i(clk), .rst_i(rst), .io_stb_i(stb), .io_we_i(we), .io_addr_i(addr),
        .io_dat_i(dati), .io_ack_o(ack), .io_dat_o(dato), .rx_byte_i(rxb),
        .rx_valid_i(rxv), .tx_byte_o(txb), .tx_start_o(txs), .tx_busy_i(busy), .irq_o(irq));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // model state: FIFOs as queues, the word being sent as a queue of remaining bytes
    logic [DW-1:0] m_rxq[$], m_txq[$];
    logic [7:0]    m_asm[$], m_pend[$], seen_tx[$];
    logic [4:0]    m_ctrl;
    logic          m_ovr, m_ovf, m_ack, m_irq, m_txs;
    logic [DW-1:0] m_dat;
    logic [7:0]    m_txb;
    int            m_phase;   // 0 idle, 1 start pulse, 2 await busy, 3 await not-busy
    int            b_pre, b_hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic          acc, flush, clr_asm, pop_rx, tx_full0, push, irq_n;
        logic [DW-1:0] rd, w;
        logic [4:0]    c0;
        if (!rst) begin
            m_rxq.delete(); m_txq.delete(); m_asm.delete(); m_pend.delete();
            m_ctrl = '0; m_ovr = 0; m_ovf = 0; m_phase = 0;
            m_ack = 0; m_irq = 0; m_txs = 0; m_dat = '0; m_txb = '0;
            return;
        end
        c0 = m_ctrl;
        irq_n = (c0[3] && m_rxq.size() != 0) || (c0[4] && m_txq.size() == 0 && m_phase == 0)
                || m_ovr || m_ovf;
        acc = stb && !m_ack;
        rd = '0; pop_rx = 0;
        if (acc && !we) begin
            case (addr)
                16'd0: rd = DW'({m_ovf, m_ovr, m_phase != 0, m_txq.size() == TXD,
                                 m_txq.size() == 0, m_rxq.size() == RXD, m_rxq.size() == 0});
                16'd2: rd = DW'(c0);
                16'd6: if (m_rxq.size() != 0) begin rd = m_rxq[0]; pop_rx = 1; end
                default: rd = '0;
            endcase
        end
        flush    = acc && we && addr == 16'd2 && dati[5];
        clr_asm  = flush || (acc && we && addr == 16'd2 && dati[2] != c0[2]);
        tx_full0 = (m_txq.size() == TXD);
        if (acc && we && addr == 16'd8) begin
            if (dati[5]) m_ovr = 0;
            if (dati[6]) m_ovf = 0;
        end
        case (m_phase)
            0: if (c0[1] && m_txq.size() != 0 && !flush) begin
                w = m_txq.pop_front();
                m_pend.delete();
                for (int i = 0; i < (c0[2] ? NB : 1); i++) m_pend.push_back(w[8*i +: 8]);
                m_txb = m_pend[0];
                m_phase = 1;
            end
            1: m_phase = 2;
            2: if (busy) m_phase = 3;
            default: if (!busy) begin
                void'(m_pend.pop_front());
                if (m_pend.size() != 0) begin m_txb = m_pend[0]; m_phase = 1; end
                else m_phase = 0;
            end
        endcase
        push = 0; w = '0;
        if (rxv && c0[0]) begin
            if (!c0[2]) begin
                push = 1; w = DW'(rxb);
            end else if (!clr_asm) begin
                m_asm.push_back(rxb);
                if (m_asm.size() == NB) begin
                    push = 1;
                    for (int i = 0; i < NB; i++) w[8*i +: 8] = m_asm[i];
                    m_asm.delete();
                end
            end
        end
        if (clr_asm) m_asm.delete();
        if (flush) begin
            m_rxq.delete(); m_txq.delete();
        end else begin
            if (pop_rx) void'(m_rxq.pop_front());
            if (push) begin
                if (m_rxq.size() == RXD) m_ovr = 1;
                else m_rxq.push_back(w);
            end
        end
        if (acc && we && addr == 16'd4) begin
            if (tx_full0) m_ovf = 1;
            else m_txq.push_back(dati);
        end
        if (acc && we && addr == 16'd2) m_ctrl = dati[4:0];
        m_ack = acc;
        m_dat = (acc && !we) ? rd : '0;
        m_irq = irq_n;
        m_txs = (m_phase == 1);
    endtask

    // one clock: model advances on the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ack", ack, m_ack);
        if (m_ack) chk("rdata", dato, m_dat);
        chk("tx_start", txs, m_txs);
        chk("tx_byte", txb, m_txb);
        chk("irq", irq, m_irq);
        if (txs) seen_tx.push_back(txb);
        if (m_txs) begin
            b_pre = $urandom_range(0, 2); b_hold = $urandom_range(1, 3); busy = 0;
        end else if (b_pre > 0) b_pre--;
        else if (b_hold > 0) begin busy = 1; b_hold--; end
        else busy = 0;
    endtask

    task automatic bus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic [DW-1:0] r);
        stb = 1; we = w; addr = a; dati = d;
        step();
        r = dato;
        stb = 0; we = 0;
        step();
    endtask

    task automatic rx_send(input logic [7:0] b);
        rxv = 1; rxb = b;
        step();
        rxv = 0;
        step();
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (seen_tx.size() < n && k < budget) begin step(); k++; end
        chk("tx_count_wait", seen_tx.size(), n);
    endtask

    logic [DW-1:0] r;
    logic [7:0]    b0, b1;

    initial begin
        rst = 0; stb = 0; we = 0; addr = '0; dati = '0; rxv = 0; rxb = '0; busy = 0;
        b_pre = 0; b_hold = 0;
        step(); step();
        chk("reset_outputs", {ack, txs, irq, txb, dato}, 0);
        rst = 1;
        step();
        bus(0, 16'd0, '0, r);
        chk("status_after_reset", r, 16'h0005);

        // single byte transmit
        bus(1, 16'd2, 16'h0002, r);
        seen_tx.delete();
        bus(1, 16'd4, 16'h1234, r);
        wait_tx(1, 40);
        b0 = (seen_tx.size() > 0) ? seen_tx[0] : 8'h00;
        chk("byte_mode_tx", b0, 8'h34);
        repeat (12) step();
        chk("byte_mode_one_start", seen_tx.size(), 1);
        bus(0, 16'd0, '0, r);
        chk("status_tx_idle", r, 16'h0005);

        // word transmit, LSB first
        bus(1, 16'd2, 16'h0006, r);
        seen_tx.delete();
        bus(1, 16'd4, 16'hBEEF, r);
        wait_tx(2, 60);
        b0 = (seen_tx.size() > 0) ? seen_tx[0] : 8'h00;
        b1 = (seen_tx.size() > 1) ? seen_tx[1] : 8'h00;
        chk("word_tx_b0", b0, 8'hEF);
        chk("word_tx_b1", b1, 8'hBE);
        repeat (12) step();

        // RX overrun
        bus(1, 16'd2, 16'h0001, r);
        for (int i = 0; i < RXD + 1; i++) rx_send(8'h40 + 8'(i));
        bus(0, 16'd0, '0, r);
        chk("status_rx_overrun", r, 16'h0026);
        for (int i = 0; i < RXD; i++) begin
            bus(0, 16'd6, '0, r);
            chk("rx_order", r, 16'h0040 + 16'(i));
        end
        bus(0, 16'd6, '0, r);
        chk("rx_empty_read", r, 16'h0000);
        bus(1, 16'd8, 16'h0020, r);
        bus(0, 16'd0, '0, r);
        chk("status_overrun_cleared", r, 16'h0005);

        // RX word framing and flush of a partial word
        bus(1, 16'd2, 16'h0005, r);
        rx_send(8'h11); rx_send(8'h22);
        bus(0, 16'd6, '0, r);
        chk("rx_word", r, 16'h2211);
        rx_send(8'h33);
        bus(1, 16'd2, 16'h0025, r);
        rx_send(8'h44); rx_send(8'h55);
        bus(0, 16'd6, '0, r);
        chk("rx_word_after_flush", r, 16'h5544);

        // push at full with a same-cycle pop
        bus(1, 16'd2, 16'h0001, r);
        for (int i = 0; i < RXD; i++) rx_send(8'h60 + 8'(i));
        stb = 1; we = 0; addr = 16'd6; rxv = 1; rxb = 8'h99;
        step();
        r = dato;
        stb = 0; rxv = 0;
        step();
        chk("full_pop_head", r, 16'h0060);
        bus(0, 16'd0, '0, r);
        chk("full_pop_no_overrun", r, 16'h0006);
        for (int i = 0; i < RXD; i++) begin
            bus(0, 16'd6, '0, r);
            chk("full_pop_order", r, (i < RXD - 1) ? 16'h0061 + 16'(i) : 16'h0099);
        end

        // RX interrupt
        bus(1, 16'd2, 16'h0009, r);
        rxv = 1; rxb = 8'h77;
        step();
        chk("irq_before", irq, 1'b0);
        rxv = 0;
        step();
        chk("irq_rx_set", irq, 1'b1);
        bus(0, 16'd6, '0, r);
        chk("irq_rx_data", r, 16'h0077);
        chk("irq_rx_clear", irq, 1'b0);

        // randomized soak
        for (int n = 0; n < 4000; n++) begin
            stb = ($urandom_range(0, 2) == 0);
            we  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: addr = 16'd0;
                1: addr = 16'd2;
                2: addr = 16'd4;
                3: addr = 16'd6;
                4: addr = 16'd8;
                default: addr = 16'd10;
            endcase
            dati = DW'($urandom);
            if (addr == 16'd2) begin
                dati[DW-1:6] = '0;
                if ($urandom_range(0, 3) != 0) dati[1:0] = 2'b11;
                dati[5] = ($urandom_range(0, 15) == 0);
            end
            rxv = ($urandom_range(0, 3) == 0);
            rxb = 8'($urandom);
            rst = ($urandom_range(0, 999) != 0);
            step();
        end
        rst = 1; stb = 0; rxv = 0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
